ppu_spr_unit: RTL and testbench

Parametrised sprite output unit for the PPU. It holds NSPR sprite channels for one scanline. Each channel has an X down-counter, attribute latch, pattern shift planes, pixel-limit counter and valid bit. During the visible line it emits one prioritised sprite pixel per i_run cycle to the background/sprite mixer. Sits between the sprite fetch FSM (which loads channels during hblank) and the pixel mixer.

---
 rtl/ppu_spr_pkg.sv | 28 ++
 rtl/ppu_spr_chan.sv | 102 ++++++++++
 rtl/ppu_spr_unit.sv | 123 ++++++++++++
 tb/tb_ppu_spr_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_spr_pkg.sv
// Shared constants and helpers for the PPU sprite output unit.
// Attribute byte layout, default geometry and plane bit reversal.
package ppu_spr_pkg;

  localparam int ATTR_PAL_LSB = 0;
  localparam int ATTR_PAL_W   = 2;
  localparam int ATTR_PRI     = 5;
  localparam int ATTR_MIRX    = 6;

  localparam int DEF_NSPR = 8;
  localparam int DEF_BPP  = 2;
  localparam int DEF_TW   = 8;
  localparam int DEF_XW   = 8;

  // Widest sprite plane the reversal helper supports.
  localparam int MAX_TW = 64;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [MAX_TW-1:0] rev_bits(input logic [MAX_TW-1:0] v, input int w);
    logic [MAX_TW-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_TW; i++) begin
      if (i < w) r[w-1-i] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ppu_spr_chan.sv
// One sprite channel: X down-counter, attribute latch, shift planes,
// pixel counter and valid bit. Reports whether it is emitting this pixel.
module ppu_spr_chan
  import ppu_spr_pkg::*;
#(
  parameter int BPP = DEF_BPP,
  parameter int TW  = DEF_TW,
  parameter int XW  = DEF_XW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  line_start,
  input  logic                  run,
  input  logic                  xcnt_we,
  input  logic [XW-1:0]         xcnt,
  input  logic                  attr_we,
  input  logic [ATTR_PAL_W-1:0] attr_pal,
  input  logic                  attr_pri,
  input  logic                  attr_mirx,
  input  logic                  patt_we,
  input  logic [BPP*TW-1:0]     patt,
  output logic                  active,
  output logic [BPP-1:0]        pix,
  output logic [ATTR_PAL_W-1:0] pal,
  output logic                  pri
);

  localparam int CW = $clog2(TW + 1);

  logic [XW-1:0]              x_q;
  logic [ATTR_PAL_W-1:0]      pal_q;
  logic                       pri_q;
  logic                       mirx_q;
  logic                       valid_q;
  logic [CW-1:0]              cnt_q;
  logic [BPP-1:0][TW-1:0]     plane_q;
  logic [BPP-1:0][TW-1:0]     plane_ld;
  logic                       mirx_eff;

  // A same-cycle attribute write decides the mirroring of the incoming pattern.
  assign mirx_eff = attr_we ? attr_mirx : mirx_q;

  always_comb begin
    plane_ld = '0;
    for (int p = 0; p < BPP; p++) begin
      if (mirx_eff)
        plane_ld[p] = TW'(rev_bits(MAX_TW'(patt[p*TW +: TW]), TW));
      else
        plane_ld[p] = patt[p*TW +: TW];
    end
  end

  assign active = valid_q && (x_q == '0) && (cnt_q < CW'(TW));
  assign pal    = pal_q;
  assign pri    = pri_q;

  always_comb begin
    pix = '0;
    for (int p = 0; p < BPP; p++) pix[p] = plane_q[p][TW-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      pal_q   <= '0;
      pri_q   <= 1'b0;
      mirx_q  <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      plane_q <= '0;
    end else begin
      if (xcnt_we)
        x_q <= xcnt;
      else if (run && (x_q != '0))
        x_q <= x_q - XW'(1);

      if (attr_we) begin
        pal_q  <= attr_pal;
        pri_q  <= attr_pri;
        mirx_q <= attr_mirx;
      end

      if (patt_we) begin
        plane_q <= plane_ld;
      end else if (run && active) begin
        for (int p = 0; p < BPP; p++) plane_q[p] <= plane_q[p] << 1;
      end

      // Loads land after the line-start clear, so a same-cycle load survives.
      if (patt_we || line_start)
        cnt_q <= '0;
      else if (run && active)
        cnt_q <= cnt_q + CW'(1);

      if (patt_we)
        valid_q <= 1'b1;
      else if (line_start)
        valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/ppu_spr_unit.sv
// Sprite output unit: NSPR channels loaded during hblank, one prioritised
// sprite pixel per i_run cycle towards the background/sprite mixer.
module ppu_spr_unit
  import ppu_spr_pkg::*;
#(
  parameter  int NSPR = DEF_NSPR,
  parameter  int BPP  = DEF_BPP,
  parameter  int TW   = DEF_TW,
  parameter  int XW   = DEF_XW,
  localparam int IW   = (NSPR > 1) ? $clog2(NSPR) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_line_start,
  input  logic [IW-1:0]             i_ld_idx,
  input  logic [XW-1:0]             i_xcnt,
  input  logic                      i_xcnt_we,
  input  logic [7:0]                i_attr,
  input  logic                      i_attr_we,
  input  logic [BPP*TW-1:0]         i_patt,
  input  logic                      i_patt_we,
  input  logic                      i_run,
  output logic                      o_vld,
  output logic                      o_show,
  output logic                      o_priority,
  output logic [ATTR_PAL_W+BPP-1:0] o_pattern,
  output logic [IW-1:0]             o_idx,
  output logic                      o_spr0
);

  // Pixel flow: a cycle with i_run=1 evaluates one pixel and the result is
  // presented on the next cycle with o_vld=1; i_run=0 gives an all-zero cycle.

  logic [NSPR-1:0]       act;
  logic [NSPR-1:0]       pri;
  logic [BPP-1:0]        pix [NSPR];
  logic [ATTR_PAL_W-1:0] pal [NSPR];

  logic                  attr_unused;
  assign attr_unused = ^{i_attr[7], i_attr[4:2]};

  for (genvar g = 0; g < NSPR; g++) begin : g_chan
    logic sel;
    // Indices beyond NSPR-1 match no channel, so such loads are dropped.
    assign sel = (32'(i_ld_idx) == g);

    ppu_spr_chan #(
      .BPP(BPP),
      .TW (TW),
      .XW (XW)
    ) u_chan (
      .clk       (i_clk),
      .rst       (i_rst),
      .line_start(i_line_start),
      .run       (i_run),
      .xcnt_we   (i_xcnt_we && sel),
      .xcnt      (i_xcnt),
      .attr_we   (i_attr_we && sel),
      .attr_pal  (i_attr[ATTR_PAL_LSB +: ATTR_PAL_W]),
      .attr_pri  (i_attr[ATTR_PRI]),
      .attr_mirx (i_attr[ATTR_MIRX]),
      .patt_we   (i_patt_we && sel),
      .patt      (i_patt),
      .active    (act[g]),
      .pix       (pix[g]),
      .pal       (pal[g]),
      .pri       (pri[g])
    );
  end

  logic                  found;
  logic [IW-1:0]         win_idx;
  logic [BPP-1:0]        win_pix;
  logic [ATTR_PAL_W-1:0] win_pal;
  logic                  win_pri;
  logic                  spr0_hit;

  // Scan high to low so the lowest opaque active channel is written last.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    win_pix = '0;
    win_pal = '0;
    win_pri = 1'b0;
    for (int i = NSPR - 1; i >= 0; i--) begin
      if (act[i] && (|pix[i])) begin
        found   = 1'b1;
        win_idx = IW'(i);
        win_pix = pix[i];
        win_pal = pal[i];
        win_pri = pri[i];
      end
    end
  end

  assign spr0_hit = act[0] && (|pix[0]);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_vld      <= 1'b0;
      o_show     <= 1'b0;
      o_priority <= 1'b0;
      o_pattern  <= '0;
      o_idx      <= '0;
      o_spr0     <= 1'b0;
    end else if (i_run) begin
      o_vld      <= 1'b1;
      o_show     <= found;
      o_priority <= win_pri;
      o_pattern  <= {win_pal, win_pix};
      o_idx      <= win_idx;
      o_spr0     <= spr0_hit;
    end else begin
      o_vld      <= 1'b0;
      o_show     <= 1'b0;
      o_priority <= 1'b0;
      o_pattern  <= '0;
      o_idx      <= '0;
      o_spr0     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ppu_spr_unit.sv
// Bench for ppu_spr_unit: table vectors, hand corner sequences, and random
// traffic checked against a pixel-index based reference model.
module tb_ppu_spr_unit;

  localparam int NSPR = 8;
  localparam int BPP  = 2;
  localparam int TW   = 8;
  localparam int XW   = 8;

  typedef struct packed {
    logic        line_start;
    logic [2:0]  ld_idx;
    logic [7:0]  xcnt;
    logic        xcnt_we;
    logic [7:0]  attr;
    logic        attr_we;
    logic [15:0] patt;
    logic        patt_we;
    logic        run;
  } vin_t;

  typedef struct packed {
    logic       vld;
    logic       show;
    logic       pri;
    logic [3:0] pat;
    logic [2:0] idx;
    logic       spr0;
  } vout_t;

  typedef struct packed {
    vin_t  i;
    vout_t o;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        line_start;
  logic [2:0]  ld_idx;
  logic [7:0]  xcnt;
  logic        xcnt_we;
  logic [7:0]  attr;
  logic        attr_we;
  logic [15:0] patt;
  logic        patt_we;
  logic        run;
  logic        o_vld, o_show, o_priority, o_spr0;
  logic [3:0]  o_pattern;
  logic [2:0]  o_idx;

  ppu_spr_unit #(.NSPR(NSPR), .BPP(BPP), .TW(TW), .XW(XW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_line_start(line_start),
    .i_ld_idx    (ld_idx),
    .i_xcnt      (xcnt),
    .i_xcnt_we   (xcnt_we),
    .i_attr      (attr),
    .i_attr_we   (attr_we),
    .i_patt      (patt),
    .i_patt_we   (patt_we),
    .i_run       (run),
    .o_vld       (o_vld),
    .o_show      (o_show),
    .o_priority  (o_priority),
    .o_pattern   (o_pattern),
    .o_idx       (o_idx),
    .o_spr0      (o_spr0)
  );

  int n_vec = 0;
  int n_bad = 0;

  // reference model: per-channel position, pixels emitted, raw pattern
  logic        m_valid    [NSPR];
  int          m_x        [NSPR];
  int          m_cnt      [NSPR];
  logic [15:0] m_patt     [NSPR];
  logic        m_mir      [NSPR];
  logic        m_attr_mir [NSPR];
  logic [1:0]  m_pal      [NSPR];
  logic        m_pri      [NSPR];

  task automatic model_reset();
    for (int c = 0; c < NSPR; c++) begin
      m_valid[c] = 1'b0; m_x[c] = 0; m_cnt[c] = 0; m_patt[c] = '0;
      m_mir[c] = 1'b0; m_attr_mir[c] = 1'b0; m_pal[c] = '0; m_pri[c] = 1'b0;
    end
  endtask

  // Pixel k of a sprite is pattern bit TW-1-k of each plane, or bit k mirrored.
  function automatic logic [1:0] m_pixel(int c);
    logic [1:0] r;
    int pos;
    pos = m_mir[c] ? m_cnt[c] : (TW - 1 - m_cnt[c]);
    for (int p = 0; p < BPP; p++) r[p] = m_patt[c][p*TW + pos];
    return r;
  endfunction

  function automatic logic m_active(int c);
    return m_valid[c] && (m_x[c] == 0) && (m_cnt[c] < TW);
  endfunction

  task automatic model_step(input vin_t v, output vout_t e);
    logic       act [NSPR];
    logic [1:0] px  [NSPR];
    logic       ld;
    e = '0;
    for (int c = 0; c < NSPR; c++) begin
      act[c] = m_active(c);
      px[c]  = act[c] ? m_pixel(c) : 2'b00;
    end
    if (v.run) begin
      e.vld  = 1'b1;
      e.spr0 = act[0] && (px[0] != 2'b00);
      for (int c = 0; c < NSPR; c++) begin
        if (act[c] && (px[c] != 2'b00)) begin
          e.show = 1'b1;
          e.pri  = m_pri[c];
          e.pat  = {m_pal[c], px[c]};
          e.idx  = 3'(c);
          break;
        end
      end
    end
    for (int c = 0; c < NSPR; c++) begin
      ld = (int'(v.ld_idx) == c);
      if (ld && v.attr_we) begin
        m_pal[c]      = v.attr[1:0];
        m_pri[c]      = v.attr[5];
        m_attr_mir[c] = v.attr[6];
      end
      if (ld && v.xcnt_we) m_x[c] = int'(v.xcnt);
      else if (v.run && m_x[c] > 0) m_x[c] = m_x[c] - 1;
      if (v.line_start || (ld && v.patt_we)) m_cnt[c] = 0;
      else if (v.run && act[c]) m_cnt[c] = m_cnt[c] + 1;
      if (ld && v.patt_we) begin
        m_valid[c] = 1'b1;
        m_patt[c]  = v.patt;
        m_mir[c]   = m_attr_mir[c];
      end else if (v.line_start) begin
        m_valid[c] = 1'b0;
      end
    end
  endtask

  // driver tasks
  task automatic drive(input vin_t v);
    line_start = v.line_start; ld_idx = v.ld_idx; xcnt = v.xcnt;
    xcnt_we = v.xcnt_we; attr = v.attr; attr_we = v.attr_we;
    patt = v.patt; patt_we = v.patt_we; run = v.run;
  endtask

  task automatic check(input vout_t exp, input string name);
    vout_t got;
    got = {o_vld, o_show, o_priority, o_pattern, o_idx, o_spr0};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got vld=%b show=%b pri=%b pat=%h idx=%0d spr0=%b, want vld=%b show=%b pri=%b pat=%h idx=%0d spr0=%b",
               name, got.vld, got.show, got.pri, got.pat, got.idx, got.spr0,
               exp.vld, exp.show, exp.pri, exp.pat, exp.idx, exp.spr0);
    end
  endtask

  task automatic step(input vin_t v, input vout_t want, input logic use_model, input string name);
    vout_t m;
    @(negedge clk);
    drive(v);
    model_step(v, m);
    @(posedge clk);
    #1;
    check(use_model ? m : want, name);
  endtask

  function automatic vin_t ld(logic ls, logic [2:0] idx, logic [7:0] x, logic [7:0] a,
                              logic [15:0] p, logic r);
    vin_t v;
    v = '0;
    v.line_start = ls; v.ld_idx = idx; v.xcnt = x; v.xcnt_we = 1'b1;
    v.attr = a; v.attr_we = 1'b1; v.patt = p; v.patt_we = 1'b1; v.run = r;
    return v;
  endfunction

  function automatic vin_t rn(logic r);
    vin_t v;
    v = '0;
    v.run = r;
    return v;
  endfunction

  function automatic vout_t ex(logic show, logic pri, logic [3:0] pat, logic [2:0] idx, logic spr0);
    vout_t o;
    o.vld = 1'b1; o.show = show; o.pri = pri; o.pat = pat; o.idx = idx; o.spr0 = spr0;
    return o;
  endfunction

  function automatic vin_t rand_in(logic ls);
    vin_t v;
    v.line_start = ls || ($urandom_range(0, 63) == 0);
    v.ld_idx     = 3'($urandom_range(0, NSPR - 1));
    v.xcnt       = 8'($urandom_range(0, 20));
    v.xcnt_we    = ($urandom_range(0, 3) == 0);
    v.attr       = 8'($urandom);
    v.attr_we    = ($urandom_range(0, 3) == 0);
    v.patt       = 16'($urandom);
    v.patt_we    = ($urandom_range(0, 3) == 0);
    v.run        = ($urandom_range(0, 4) != 0);
    return v;
  endfunction

  vec_t        tbl [14];
  localparam vout_t ZERO = '0;
  localparam vout_t DARK = 11'b100_0000_000_0;

  initial begin
    // table: ch0 at x=3, palette 1, plane1=0x80 plane0=0xFF
    tbl[0].i = ld(1'b1, 3'd0, 8'd3, 8'h01, 16'h80FF, 1'b0);
    tbl[0].o = ZERO;
    for (int k = 1; k <= 12; k++) begin
      tbl[k].i = rn(1'b1);
      if (k == 4)                tbl[k].o = ex(1'b1, 1'b0, 4'h7, 3'd0, 1'b1);
      else if (k >= 5 && k <= 11) tbl[k].o = ex(1'b1, 1'b0, 4'h5, 3'd0, 1'b1);
      else                        tbl[k].o = DARK;
    end
    tbl[13].i = rn(1'b0);
    tbl[13].o = ZERO;

    rst = 1'b1;
    drive('0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check(ZERO, "reset_state");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) step(tbl[i].i, tbl[i].o, 1'b0, $sformatf("tbl%0d", i));

    // mirror: attr written with the pattern, old attr had mirror clear
    step(ld(1'b1, 3'd0, 8'd0, 8'h40, 16'h80FF, 1'b0), ZERO, 1'b0, "mir_ld");
    for (int k = 0; k < 7; k++) step(rn(1'b1), ex(1'b1, 1'b0, 4'h1, 3'd0, 1'b1), 1'b0, "mir_px");
    step(rn(1'b1), ex(1'b1, 1'b0, 4'h3, 3'd0, 1'b1), 1'b0, "mir_px7");
    step(rn(1'b1), DARK, 1'b0, "mir_end");

    // ch2 transparent at pixel 0, ch5 opaque
    step(ld(1'b1, 3'd2, 8'd0, 8'h02, 16'h7F7F, 1'b0), ZERO, 1'b0, "prio_ld2");
    step(ld(1'b0, 3'd5, 8'd0, 8'h03, 16'h00FF, 1'b0), ZERO, 1'b0, "prio_ld5");
    step(rn(1'b1), ex(1'b1, 1'b0, 4'hD, 3'd5, 1'b0), 1'b0, "prio_ch5");
    step(rn(1'b1), ex(1'b1, 1'b0, 4'hB, 3'd2, 1'b0), 1'b0, "prio_ch2");

    // ch0 (behind background) over ch1, then ch0 transparent
    step(ld(1'b1, 3'd0, 8'd0, 8'h20, 16'h0080, 1'b0), ZERO, 1'b0, "spr0_ld0");
    step(ld(1'b0, 3'd1, 8'd0, 8'h01, 16'hFF00, 1'b0), ZERO, 1'b0, "spr0_ld1");
    step(rn(1'b1), ex(1'b1, 1'b1, 4'h1, 3'd0, 1'b1), 1'b0, "spr0_win");
    step(rn(1'b1), ex(1'b1, 1'b0, 4'h6, 3'd1, 1'b0), 1'b0, "spr0_lose");

    // line_start with ch3 load; run gaps must not advance
    step(ld(1'b1, 3'd3, 8'd1, 8'h00, 16'h00AA, 1'b0), ZERO, 1'b0, "ls_ld3");
    step(rn(1'b1), DARK, 1'b0, "ls_x1");
    step(rn(1'b0), ZERO, 1'b0, "gap0");
    step(rn(1'b1), ex(1'b1, 1'b0, 4'h1, 3'd3, 1'b0), 1'b0, "ls_px0");
    step(rn(1'b0), ZERO, 1'b0, "gap1");
    step(rn(1'b0), ZERO, 1'b0, "gap2");
    step(rn(1'b1), DARK, 1'b0, "ls_px1");
    step(rn(1'b1), ex(1'b1, 1'b0, 4'h1, 3'd3, 1'b0), 1'b0, "ls_px2");

    // reset mid-line
    step(ld(1'b1, 3'd0, 8'd0, 8'h00, 16'h00FF, 1'b0), ZERO, 1'b0, "rm_ld");
    step(rn(1'b1), ex(1'b1, 1'b0, 4'h1, 3'd0, 1'b1), 1'b0, "rm_run");
    @(negedge clk);
    rst = 1'b1;
    drive(rn(1'b1));
    #1;
    check(ZERO, "rm_async");
    @(posedge clk);
    #1;
    check(ZERO, "rm_hold");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) step(rn(1'b1), DARK, 1'b0, "rm_after");

    // random lines against the model
    for (int line = 0; line < 25; line++) begin
      step(rand_in(1'b1), ZERO, 1'b1, "rand_ls");
      for (int c = 0; c < 60; c++) step(rand_in(1'b0), ZERO, 1'b1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
